register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised multi-write-port register file with an integrated scoreboard, for the pipelined CPU datapath.
- Two asynchronous read ports with optional write-to-read bypass; two synchronous write ports: port 0 is ALU writeback, port 1 is load writeback.
- A per-register pending bit is set when the issue stage claims a destination and cleared when that register is written back. The issue stage uses these bits to detect hazards.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W registers
- BYPASS, 1, 1: read ports return same-cycle write data for a matching address; 0: read ports return stored value only
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and claims, never pending; 0: register 0 is ordinary

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- busy_a  out  1  pending bit of rd_addr_a (combinational)
- busy_b  out  1  pending bit of rd_addr_b (combinational)
- wr_en0  in  1  write port 0 enable
- wr_addr0  in  ADDR_W  write port 0 address
- wr_data0  in  DATA_W  write port 0 data
- wr_en1  in  1  write port 1 enable
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- claim_en  in  1  mark claim_addr pending
- claim_addr  in  ADDR_W  destination being claimed
- pending_cnt  out  ADDR_W+1  number of pending registers (registered)
- conflict_err  out  1  sticky error flag (registered)

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, all registers, pending bits, pending_cnt and conflict_err go to 0. All other inputs are ignored that cycle.
- While rst=1, rd_data_a/b read 0 and bypass is disabled.
- Reads: rd_data_x = mem[rd_addr_x], zero latency.
- With BYPASS=1, a matching enabled write in the same cycle overrides the stored value.
  - Source priority: port 0 match, then port 1 match, then mem.
- busy_x = pending[rd_addr_x]. busy_x is not bypassed: a write clearing the bit shows busy_x=0 only from the next cycle.
- Writes are committed on the rising edge, one-cycle write-to-storage latency.
  - Both ports enabled to the same address: port 0 data is stored and conflict_err is set.
  - Both ports enabled to different addresses: both are stored.
- Pending bit per register, next state:
  - set if claim_en && claim_addr==r
  - else cleared if (wr_en0 && wr_addr0==r) || (wr_en1 && wr_addr1==r)
  - else held
  - Claim and write to the same register in the same cycle: claim wins; the bit stays or becomes 1 and the data is still written.
- conflict_err is set, and remains set until rst, when:
  - claim_en targets a register whose pending bit is already 1 (WAW double claim)
  - a write-port address collision occurs
  - A write to a non-pending register is legal and raises no error.
- pending_cnt is registered and equals the popcount of the pending bits after the edge. Range 0 .. 2**ADDR_W, so the width needs no wrap.
- ZERO_REG=1:
  - reads of address 0 return 0, including via bypass
  - writes and claims to address 0 are dropped and raise no error
  - pending[0] is constant 0, so pending_cnt maximum is 2**ADDR_W-1
  - A write-port collision on address 0 raises no error.
- Reset mid-operation: pending state and in-flight claims are discarded; outstanding writebacks after reset are plain writes.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then read addresses 0..15 -> all rd_data 0, busy 0, pending_cnt 0, conflict_err 0.
- Write and bypass, BYPASS=1:
  - wr_en0, addr 3, data 32'hA5A5A5A5, with rd_addr_a=3 in the same cycle -> rd_data_a=A5A5A5A5 that cycle and the next.
  - With BYPASS=0 -> 0 that cycle, A5A5A5A5 next.
- Scoreboard:
  - claim 5 -> busy_a(5)=1, pending_cnt=1 next cycle.
  - wr_en1 addr 5 data 32'h12345678 -> busy 0, pending_cnt 0 the following cycle; rd_data=12345678.
- Simultaneous events:
  - claim 7 and wr_en0 addr 7 in the same cycle -> pending[7]=1, data stored.
  - Claim 7 again -> conflict_err=1 and stays 1 until rst.
- Port collision: wr_en0 and wr_en1 both to addr 9 with data 1 and 2 -> mem[9]=1, conflict_err=1.
- Zero register, ZERO_REG=1: write 32'hFFFFFFFF to 0 and claim 0 -> rd_data 0, busy 0, pending_cnt 0, conflict_err 0.

Source files
------------

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : register_file_sb
// Description : Two-read / two-write register file with a per-register pending
//               scoreboard for issue-stage hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [ADDR_W:0]   pending_cnt,
    output logic              conflict_err
);

    localparam int unsigned c_DEPTH = 2**ADDR_W;
    localparam int unsigned c_CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]  mem_q [c_DEPTH];
    logic [c_DEPTH-1:0] pending_q;
    logic [c_DEPTH-1:0] pending_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               err_q;
    logic               err_d;

    logic w_we0;
    logic w_we1;
    logic w_claim;
    logic w_collide;
    logic w_waw;

    // Accesses to a hardwired zero register are dropped before they reach any state.
    assign w_we0   = wr_en0   && !(ZERO_REG && (wr_addr0   == '0));
    assign w_we1   = wr_en1   && !(ZERO_REG && (wr_addr1   == '0));
    assign w_claim = claim_en && !(ZERO_REG && (claim_addr == '0));

    assign w_collide = w_we0 && w_we1 && (wr_addr0 == wr_addr1);
    assign w_waw     = w_claim && pending_q[claim_addr];
    assign err_d     = err_q | w_waw | w_collide;

    // Claim takes precedence over a same-cycle writeback of that register.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < c_DEPTH; i++) begin
            if (w_claim && (claim_addr == ADDR_W'(i))) begin
                pending_d[i] = 1'b1;
            end else if ((w_we0 && (wr_addr0 == ADDR_W'(i))) ||
                         (w_we1 && (wr_addr1 == ADDR_W'(i)))) begin
                pending_d[i] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            cnt_d = cnt_d + c_CNT_W'(pending_d[i]);
        end
    end

    // Port 0 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (w_we1) begin
                mem_q[wr_addr1] <= wr_data1;
            end
            if (w_we0) begin
                mem_q[wr_addr0] <= wr_data0;
            end
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = (p == 0) ? rd_addr_a : rd_addr_b;

        always_comb begin
            w_data = mem_q[w_addr];
            if (rst || (ZERO_REG && (w_addr == '0))) begin
                w_data = '0;
            end else if (BYPASS && wr_en0 && (wr_addr0 == w_addr)) begin
                w_data = wr_data0;
            end else if (BYPASS && wr_en1 && (wr_addr1 == w_addr)) begin
                w_data = wr_data1;
            end
        end

        if (p == 0) begin : g_port_a
            assign rd_data_a = w_data;
        end else begin : g_port_b
            assign rd_data_b = w_data;
        end
    end

    assign busy_a       = pending_q[rd_addr_a];
    assign busy_b       = pending_q[rd_addr_b];
    assign pending_cnt  = cnt_q;
    assign conflict_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_sb
// Description : Self-checking bench; default instance plus a BYPASS=0,
//               ZERO_REG=0 instance driven by the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_sb;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr0, wr_addr1, claim_addr;
    logic          wr_en0, wr_en1, claim_en;
    logic [DW-1:0] wr_data0, wr_data1;
    logic [DW-1:0] da, db, na, nb;
    logic          ba, bb, nba, nbb, err, nerr;
    logic [AW:0]   cnt, ncnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    register_file_sb u_dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(da), .rd_data_b(db), .busy_a(ba), .busy_b(bb),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .pending_cnt(cnt), .conflict_err(err)
    );

    register_file_sb #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(na), .rd_data_b(nb), .busy_a(nba), .busy_b(nbb),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .pending_cnt(ncnt), .conflict_err(nerr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        claim_en = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en0 = 1'b1; wr_addr0 = 4'd3; wr_data0 = 32'hCAFEF00D;
        claim_en = 1'b1; claim_addr = 4'd4;
        rd_addr_a = 4'd3;
        tick();
        checks++; if (da !== 32'h0) begin errors++; $display("FAIL rst_no_bypass got=%h exp=%h", da, 32'h0); end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (cnt !== 5'd0 || ncnt !== 5'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0", cnt, ncnt); end
        checks++; if (err !== 1'b0 || nerr !== 1'b0) begin errors++; $display("FAIL rst_err got=%b/%b exp=0", err, nerr); end
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = AW'(a);
            rd_addr_b = AW'(15 - a);
            #1;
            checks++; if (da !== 32'h0 || db !== 32'h0 || na !== 32'h0 || nb !== 32'h0) begin
                errors++; $display("FAIL rst_read a=%0d got=%h %h %h %h exp=0", a, da, db, na, nb);
            end
            checks++; if (ba !== 1'b0 || bb !== 1'b0 || nba !== 1'b0 || nbb !== 1'b0) begin
                errors++; $display("FAIL rst_busy a=%0d got=%b%b%b%b exp=0000", a, ba, bb, nba, nbb);
            end
        end
    endtask

    task automatic test_bypass();
        rd_addr_a = 4'd3;
        wr_en0 = 1'b1; wr_addr0 = 4'd3; wr_data0 = 32'hA5A5A5A5;
        #1;
        checks++; if (da !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass0_same got=%h exp=%h", da, 32'hA5A5A5A5); end
        checks++; if (na !== 32'h0) begin errors++; $display("FAIL nobypass_same got=%h exp=%h", na, 32'h0); end
        tick();
        idle();
        #1;
        checks++; if (da !== 32'hA5A5A5A5 || na !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next got=%h/%h exp=%h", da, na, 32'hA5A5A5A5); end
        rd_addr_b = 4'd6;
        wr_en1 = 1'b1; wr_addr1 = 4'd6; wr_data1 = 32'h00000066;
        #1;
        checks++; if (db !== 32'h66) begin errors++; $display("FAIL bypass1_same got=%h exp=%h", db, 32'h66); end
        checks++; if (nb !== 32'h0) begin errors++; $display("FAIL nobypass1_same got=%h exp=%h", nb, 32'h0); end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        exp_t e;
        claim_en = 1'b1; claim_addr = 4'd5;
        rd_addr_a = 4'd5;
        #1;
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL claim_same_cycle_busy got=%b exp=0", ba); end
        tick();
        idle();
        #1;
        checks++; if (ba !== 1'b1 || nba !== 1'b1) begin errors++; $display("FAIL claim_busy got=%b/%b exp=1", ba, nba); end
        checks++; if (cnt !== 5'd1 || ncnt !== 5'd1) begin errors++; $display("FAIL claim_cnt got=%0d/%0d exp=1", cnt, ncnt); end
        wr_en1 = 1'b1; wr_addr1 = 4'd5; wr_data1 = 32'h12345678;
        sb_q.push_back('{addr: 4'd5, data: 32'h12345678});
        #1;
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL busy_not_bypassed got=%b exp=1", ba); end
        checks++; if (da !== 32'h12345678) begin errors++; $display("FAIL wb_bypass got=%h exp=%h", da, 32'h12345678); end
        tick();
        idle();
        e = sb_q.pop_front();
        rd_addr_a = e.addr;
        #1;
        checks++; if (da !== e.data || na !== e.data) begin errors++; $display("FAIL wb_data got=%h/%h exp=%h", da, na, e.data); end
        checks++; if (ba !== 1'b0 || cnt !== 5'd0) begin errors++; $display("FAIL wb_clear got busy=%b cnt=%0d exp busy=0 cnt=0", ba, cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wb_err got=%b exp=0", err); end
    endtask

    task automatic test_simultaneous();
        claim_en = 1'b1; claim_addr = 4'd7;
        wr_en0 = 1'b1; wr_addr0 = 4'd7; wr_data0 = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr_a = 4'd7;
        #1;
        checks++; if (ba !== 1'b1 || cnt !== 5'd1) begin errors++; $display("FAIL claim_wins got busy=%b cnt=%0d exp busy=1 cnt=1", ba, cnt); end
        checks++; if (da !== 32'hDEADBEEF || na !== 32'hDEADBEEF) begin errors++; $display("FAIL claim_wr_data got=%h/%h exp=%h", da, na, 32'hDEADBEEF); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL claim_wr_err got=%b exp=0", err); end
        claim_en = 1'b1; claim_addr = 4'd7;
        tick();
        idle();
        #1;
        checks++; if (err !== 1'b1 || nerr !== 1'b1) begin errors++; $display("FAIL waw_err got=%b/%b exp=1", err, nerr); end
        tick();
        tick();
        wr_en1 = 1'b1; wr_addr1 = 4'd7; wr_data1 = 32'h1;
        tick();
        idle();
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        checks++; if (ba !== 1'b0 || cnt !== 5'd0) begin errors++; $display("FAIL waw_clear got busy=%b cnt=%0d exp busy=0 cnt=0", ba, cnt); end
        do_reset();
        #1;
        checks++; if (err !== 1'b0 || nerr !== 1'b0) begin errors++; $display("FAIL err_reset got=%b/%b exp=0", err, nerr); end
    endtask

    task automatic test_collision();
        wr_en0 = 1'b1; wr_addr0 = 4'd9; wr_data0 = 32'd1;
        wr_en1 = 1'b1; wr_addr1 = 4'd9; wr_data1 = 32'd2;
        rd_addr_a = 4'd9;
        #1;
        checks++; if (da !== 32'd1) begin errors++; $display("FAIL coll_bypass_prio got=%h exp=%h", da, 32'd1); end
        checks++; if (na !== 32'd0) begin errors++; $display("FAIL coll_nobypass got=%h exp=%h", na, 32'd0); end
        tick();
        idle();
        #1;
        checks++; if (da !== 32'd1 || na !== 32'd1) begin errors++; $display("FAIL coll_stored got=%h/%h exp=%h", da, na, 32'd1); end
        checks++; if (err !== 1'b1 || nerr !== 1'b1) begin errors++; $display("FAIL coll_err got=%b/%b exp=1", err, nerr); end
        do_reset();
    endtask

    task automatic test_zero_reg();
        wr_en0 = 1'b1; wr_addr0 = 4'd0; wr_data0 = 32'hFFFFFFFF;
        claim_en = 1'b1; claim_addr = 4'd0;
        rd_addr_a = 4'd0;
        #1;
        checks++; if (da !== 32'h0) begin errors++; $display("FAIL zero_bypass got=%h exp=%h", da, 32'h0); end
        tick();
        idle();
        #1;
        checks++; if (da !== 32'h0 || ba !== 1'b0 || cnt !== 5'd0 || err !== 1'b0) begin
            errors++; $display("FAIL zero_reg got data=%h busy=%b cnt=%0d err=%b exp 0/0/0/0", da, ba, cnt, err);
        end
        checks++; if (na !== 32'hFFFFFFFF || nba !== 1'b1 || ncnt !== 5'd1 || nerr !== 1'b0) begin
            errors++; $display("FAIL ordinary_reg0 got data=%h busy=%b cnt=%0d err=%b exp ffffffff/1/1/0", na, nba, ncnt, nerr);
        end
        wr_en0 = 1'b1; wr_addr0 = 4'd0; wr_data0 = 32'd1;
        wr_en1 = 1'b1; wr_addr1 = 4'd0; wr_data1 = 32'd2;
        tick();
        idle();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_coll_err got=%b exp=0", err); end
        checks++; if (nerr !== 1'b1) begin errors++; $display("FAIL reg0_coll_err got=%b exp=1", nerr); end
        do_reset();
        for (int a = 0; a < 16; a++) begin
            claim_en = 1'b1; claim_addr = AW'(a);
            tick();
        end
        idle();
        #1;
        checks++; if (cnt !== 5'd15) begin errors++; $display("FAIL cnt_max_zero got=%0d exp=15", cnt); end
        checks++; if (ncnt !== 5'd16) begin errors++; $display("FAIL cnt_max_full got=%0d exp=16", ncnt); end
        checks++; if (err !== 1'b0 || nerr !== 1'b0) begin errors++; $display("FAIL cnt_max_err got=%b/%b exp=0", err, nerr); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        claim_en = 1'b1; claim_addr = 4'd8;
        tick();
        claim_en = 1'b1; claim_addr = 4'd10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        rd_addr_a = 4'd8; rd_addr_b = 4'd10;
        #1;
        checks++; if (cnt !== 5'd0 || ba !== 1'b0 || bb !== 1'b0) begin errors++; $display("FAIL mid_rst got cnt=%0d busy=%b%b exp 0/00", cnt, ba, bb); end
        wr_en0 = 1'b1; wr_addr0 = 4'd8; wr_data0 = 32'h77;
        tick();
        idle();
        #1;
        checks++; if (da !== 32'h77 || err !== 1'b0 || cnt !== 5'd0) begin errors++; $display("FAIL mid_rst_wb got data=%h err=%b cnt=%0d exp 77/0/0", da, err, cnt); end
    endtask

    task automatic test_fill();
        exp_t e;
        for (int a = 1; a < 16; a++) begin
            logic [DW-1:0] d;
            d = $urandom;
            if (a % 2 == 1) begin
                wr_en0 = 1'b1; wr_addr0 = AW'(a); wr_data0 = d;
            end else begin
                wr_en1 = 1'b1; wr_addr1 = AW'(a); wr_data1 = d;
            end
            sb_q.push_back('{addr: AW'(a), data: d});
            tick();
            idle();
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_addr_a = e.addr;
            rd_addr_b = e.addr;
            #1;
            checks++; if (da !== e.data || db !== e.data || na !== e.data) begin
                errors++; $display("FAIL fill a=%0d got=%h %h %h exp=%h", e.addr, da, db, na, e.data);
            end
        end
        checks++; if (err !== 1'b0 || cnt !== 5'd0) begin errors++; $display("FAIL fill_err got err=%b cnt=%0d exp 0/0", err, cnt); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr_a = '0; rd_addr_b = '0;
        wr_addr0 = '0; wr_addr1 = '0; claim_addr = '0;
        wr_data0 = '0; wr_data1 = '0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_collision();
        test_zero_reg();
        test_reset_mid();
        test_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
